// File: rtl/mem_access_unit.sv
// Load/store initiator between the pipeline MEM stage and a word-wide data_mem.
// Sub-word loads are lane-extracted and extended; sub-word stores use read-modify-write.
//
// state   | meaning
// IDLE    | ready for a request
// READ    | mem_read strobe, one cycle
// CAPTURE | latch read word, extend load data or merge store lane
// WRITE   | mem_write strobe, one cycle
// RESP    | resp_valid pulse with registered result
module mem_access_unit #(
    parameter int SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_err = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (req_addr >= ADDR_LIMIT);

    always_comb begin
        rd_byte = mem_read_data[7:0];
        case (addr_q[1:0])
            2'd0: rd_byte = mem_read_data[7:0];
            2'd1: rd_byte = mem_read_data[15:8];
            2'd2: rd_byte = mem_read_data[23:16];
            2'd3: rd_byte = mem_read_data[31:24];
            default: rd_byte = mem_read_data[7:0];
        endcase
        rd_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

        case (size_q)
            2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_ext = mem_read_data;
        endcase
    end

    // Store merge: the read word with only the addressed lane replaced.
    always_comb begin
        merged = mem_read_data;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                2'd3: merged[31:24] = wdata_q[7:0];
                default: merged = mem_read_data;
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        write_d  = write_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    write_d  = req_write;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_err;
                    if (req_err)
                        state_d = S_RESP;
                    else if (req_write && req_size == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ:  state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (write_q) begin
                    wdata_d = merged;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    logic mem_busy;
    assign mem_busy       = (state_q == S_READ) || (state_q == S_CAPTURE) || (state_q == S_WRITE);
    assign req_ready      = (state_q == S_IDLE);
    assign mem_read       = (state_q == S_READ);
    assign mem_write      = (state_q == S_WRITE);
    assign mem_address    = mem_busy ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_write_data = (state_q == S_WRITE) ? wdata_q : 32'd0;
    assign resp_valid     = (state_q == S_RESP);
    assign resp_rdata     = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign resp_err       = (state_q == S_RESP) ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single requests plus
// hand-written read-modify-write, reset-abort and back-to-back sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    mem_access_unit #(.SIZE(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // data_mem model: read data valid the cycle after mem_read; reloaded while in reset
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[4] <= 32'hA1B2C3D4;
            mem_read_data <= 32'd0;
        end else begin
            if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
            if (mem_read) mem_read_data <= mem[mem_address[11:2]];
        end
    end

    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          both_cnt = 0;
    int          resp_cnt = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;
    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) begin
            wr_cnt++;
            last_wr_addr = mem_address;
            last_wr_data = mem_write_data;
        end
        if (mem_read && mem_write) both_cnt++;
        if (resp_valid) resp_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    task automatic do_req(input vec_t v, input string tag);
        int   lat;
        int   waitc;
        int   rd0;
        int   wr0;
        logic got;
        @(negedge clk);
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_valid  = 1'b1;
        waitc = 0;
        while (!req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (resp_valid) got = 1'b1;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, resp_rdata, v.exp_rdata);
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
        chk({tag, "_nread"}, 32'(rd_cnt - rd0), 32'(v.exp_rd));
        chk({tag, "_nwrite"}, 32'(wr_cnt - wr0), 32'(v.exp_wr));
    endtask

    vec_t vecs[14];
    vec_t v;
    int   resp0;
    int   wr0;
    int   busy;
    int   nw;
    int   nresp;
    logic [31:0] w_addr [0:3];
    logic [31:0] w_data [0:3];

    initial begin
        //            wr    size   sgn   addr          wdata         exp_rdata      err  lat rd wr
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hA1B2C3D4, 1'b0, 3, 1, 0};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0,        32'hFFFFFFA1, 1'b0, 3, 1, 0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'h000000A1, 1'b0, 3, 1, 0};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFFA1B2, 1'b0, 3, 1, 0};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'h0000C3D4, 1'b0, 3, 1, 0};
        vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,        32'hFFFFFFD4, 1'b0, 3, 1, 0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'h0000A1B2, 1'b0, 3, 1, 0};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        32'h000000C3, 1'b0, 3, 1, 0};
        vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0,        32'hFFFFFFB2, 1'b0, 3, 1, 0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0FFC, 32'h0,        32'h00000000, 1'b0, 3, 1, 0};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
        vecs[11] = '{1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h12345678, 32'h00000000, 1'b1, 1, 0, 0};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};
        vecs[13] = '{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'h00000000, 1'b1, 1, 0, 0};

        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) do_req(vecs[i], $sformatf("vec%0d", i));

        v = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h123456EE, 32'h0, 1'b0, 4, 1, 1};
        do_req(v, "sb");
        chk("sb_wdata", last_wr_data, 32'hA1B2EED4);
        chk("sb_waddr", last_wr_addr, 32'h0000_0010);
        v = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hA1B2EED4, 1'b0, 3, 1, 0};
        do_req(v, "lw_after_sb");

        v = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h5555BEEF, 32'h0, 1'b0, 4, 1, 1};
        do_req(v, "sh");
        chk("sh_wdata", last_wr_data, 32'hBEEFEED4);
        v = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'hBEEFEED4, 1'b0, 3, 1, 0};
        do_req(v, "lw_after_sh");

        // reset while an lw sits in CAPTURE
        @(negedge clk);
        req_write = 1'b0;
        req_size = 2'b10;
        req_addr = 32'h0000_0010;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_read_phase", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        resp0 = resp_cnt;
        reset = 1'b1;
        #1;
        chk("abort_mem_read", {31'd0, mem_read}, 32'd0);
        chk("abort_mem_write", {31'd0, mem_write}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_mem_address", mem_address, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_resp", 32'(resp_cnt - resp0), 32'd0);
        v = '{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1};
        do_req(v, "sw_after_rst");
        chk("sw_after_rst_wdata", last_wr_data, 32'hDEADBEEF);
        chk("sw_after_rst_waddr", last_wr_addr, 32'h0000_0020);

        // back-to-back word stores with req_valid held high
        @(negedge clk);
        req_write = 1'b1;
        req_size = 2'b10;
        req_addr = 32'h0000_0020;
        req_wdata = 32'h11111111;
        req_valid = 1'b1;
        chk("b2b_ready0", {31'd0, req_ready}, 32'd1);
        wr0 = wr_cnt;
        nw = 0;
        nresp = 0;
        busy = 0;
        @(posedge clk);
        #1;
        req_addr = 32'h0000_0024;
        req_wdata = 32'h22222222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write && nw < 4) begin
                w_addr[nw] = mem_address;
                w_data[nw] = mem_write_data;
                nw++;
            end
            if (resp_valid) nresp++;
            if (req_ready) break;
            busy++;
        end
        chk("b2b_busy_cycles", 32'(busy), 32'd2);
        chk("b2b_first_resp", 32'(nresp), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_write && nw < 4) begin
                w_addr[nw] = mem_address;
                w_data[nw] = mem_write_data;
                nw++;
            end
            if (resp_valid) begin
                nresp++;
                break;
            end
        end
        chk("b2b_resp_count", 32'(nresp), 32'd2);
        chk("b2b_write_count", 32'(wr_cnt - wr0), 32'd2);
        chk("b2b_write_seen", 32'(nw), 32'd2);
        if (nw >= 2) begin
            chk("b2b_addr0", w_addr[0], 32'h0000_0020);
            chk("b2b_data0", w_data[0], 32'h11111111);
            chk("b2b_addr1", w_addr[1], 32'h0000_0024);
            chk("b2b_data1", w_data[1], 32'h22222222);
        end
        chk("strobe_overlap", 32'(both_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
